// File: rtl/abro_pkg.sv
// abro_pkg -- shared definitions for the ABRO event-detection FSM.
//   abro_state_t : 2-bit state type. The encodings are part of the external
//                  interface because the top module exports the raw state:
//                  IDLE=00, GOT_A=01, GOT_B=10, DONE=11.
package abro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10,
    DONE  = 2'b11
  } abro_state_t;

endpackage

// File: rtl/abro_sync2.sv
// abro_sync2 -- two-flop synchronizer for one asynchronous input.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-low reset; both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, delayed by two clk edges
module abro_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/abro_state_machine.sv
// abro_state_machine -- ABRO detector: O asserts once both events A and B
// have been seen (in any order, or together); only reset re-arms it.
// Parameters:
//   O_PULSE : 0 = O held high for as long as the FSM is in DONE
//             1 = O high for one cycle on entry into DONE
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (state=IDLE, O=0)
//   A, B  : event inputs, level-sampled at posedge clk
//   O     : registered "both A and B seen" indication
//   state : registered FSM state (IDLE=00, GOT_A=01, GOT_B=10, DONE=11)
// Build option:
//   ABRO_INPUT_SYNC_EN : when defined, A and B pass through abro_sync2
//                        two-flop synchronizers (+2 cycles latency).
module abro_state_machine
  import abro_pkg::*;
#(
  parameter int unsigned O_PULSE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  output logic       O,
  output logic [1:0] state
);

  logic        a_in;
  logic        b_in;
  abro_state_t state_q;
  abro_state_t state_d;
  logic        o_q;
  logic        o_d;

`ifdef ABRO_INPUT_SYNC_EN
  abro_sync2 u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (A),
    .q     (a_in)
  );

  abro_sync2 u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (B),
    .q     (b_in)
  );
`else
  assign a_in = A;
  assign b_in = B;
`endif

  // Next state: events latch until reset; DONE is absorbing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (a_in && b_in) state_d = DONE;
        else if (a_in)    state_d = GOT_A;
        else if (b_in)    state_d = GOT_B;
      end
      GOT_A:   if (b_in) state_d = DONE;
      GOT_B:   if (a_in) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // O is computed from the next state so it registers on the same edge
  // that moves the FSM into DONE.
  always_comb begin
    o_d = 1'b0;
    if (O_PULSE == 0) o_d = (state_d == DONE);
    else              o_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
    end
  end

  assign state = state_q;
  assign O     = o_q;

endmodule

// File: tb/tb_abro_state_machine.sv
// tb_abro_state_machine -- randomized scoreboard bench for abro_state_machine.
// Two instances (O_PULSE=0 and O_PULSE=1) share the stimulus. The reference
// model tracks "A seen" / "B seen" flags; expected state is {B seen, A seen}.
// Honours ABRO_INPUT_SYNC_EN by delaying the modelled inputs two cycles.
module tb_abro_state_machine;

`ifdef ABRO_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int TAP = (LAT > 0) ? LAT - 1 : 0;

  logic       clk;
  logic       reset;
  logic       A;
  logic       B;
  logic       O0;
  logic       O1;
  logic [1:0] state0;
  logic [1:0] state1;

  abro_state_machine #(.O_PULSE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .O     (O0),
    .state (state0)
  );

  abro_state_machine #(.O_PULSE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .O     (O1),
    .state (state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_evt;
    logic [1:0] st;
    logic       o0;
    logic       o1;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  bit seen_a = 1'b0;
  bit seen_b = 1'b0;
  bit pa[2]  = '{1'b0, 1'b0};
  bit pb[2]  = '{1'b0, 1'b0};

  task automatic model_reset();
    seen_a = 1'b0;
    seen_b = 1'b0;
    pa     = '{1'b0, 1'b0};
    pb     = '{1'b0, 1'b0};
  endtask

  task automatic push_exp(input bit rst_evt, input logic [1:0] st,
                          input logic o0, input logic o1);
    exp_t e;
    e.rst_evt = rst_evt;
    e.st      = st;
    e.o0      = o0;
    e.o1      = o1;
    q.push_back(e);
  endtask

  // Apply one cycle of stimulus just after a falling clk edge and queue the
  // response expected at the coming rising edge (and at the reset assertion
  // itself, if reset falls here).
  task automatic step(input logic r, input logic a, input logic b);
    bit a_eff;
    bit b_eff;
    bit prev_both;
    bit both;
    if (reset === 1'b1 && r == 1'b0) begin
      push_exp(1'b1, 2'b00, 1'b0, 1'b0);
      model_reset();
    end
    reset = r;
    A     = a;
    B     = b;
    if (r == 1'b0) begin
      model_reset();
      push_exp(1'b0, 2'b00, 1'b0, 1'b0);
    end else begin
      a_eff = a;
      b_eff = b;
      if (LAT > 0) begin
        a_eff = pa[TAP];
        b_eff = pb[TAP];
        pa[1] = pa[0];
        pb[1] = pb[0];
        pa[0] = a;
        pb[0] = b;
      end
      prev_both = seen_a && seen_b;
      seen_a    = seen_a || a_eff;
      seen_b    = seen_b || b_eff;
      both      = seen_a && seen_b;
      push_exp(1'b0, {seen_b, seen_a}, both, both && !prev_both);
    end
    @(negedge clk);
  endtask

  task automatic check(input exp_t e);
    vectors++;
    if (state0 !== e.st || state1 !== e.st || O0 !== e.o0 || O1 !== e.o1) begin
      miscompares++;
      $display("FAIL %s @%0t: state0=%b state1=%b O0=%b O1=%b, expected state=%b O0=%b O1=%b",
               e.rst_evt ? "reset_assert" : "clk_edge", $time,
               state0, state1, O0, O1, e.st, e.o0, e.o1);
    end
  endtask

  // Monitors: clock-edge responses and asynchronous reset responses.
  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() > 0 && !q[0].rst_evt) check(q.pop_front());
  end

  initial forever begin
    @(negedge reset);
    #2;
    if (q.size() > 0 && q[0].rst_evt) check(q.pop_front());
  end

  initial begin
    A = 1'b0;
    B = 1'b0;
    // 10 ns of reset with A=B=0, then release
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // A pulse, gap, then B: 01, 01, 11
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    // toggle inputs while in DONE
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    // reset mid-cycle, then A=B=1 on the first edge after release
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // B then A
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // A held high many cycles, then B
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0));
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never observed, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
